// File: rtl/router_pkg.sv
// Shared constants, types and controller state encodings for the 1x3 router datapath.
package router_pkg;

    localparam int unsigned DATA_WIDTH   = 8;
    localparam logic [1:0]  INVALID_ADDR = 2'b11;

    typedef logic [DATA_WIDTH-1:0] byte_t;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

    typedef struct packed {
        logic detect_addr;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic rst_int_reg;
    } strobes_t;

    // Header bits [1:0] carry the destination; code 2'b11 has no port behind it.
    function automatic logic addr_valid(byte_t b);
        return b[1:0] != INVALID_ADDR;
    endfunction

    function automatic strobes_t state_strobes(router_state_e s);
        strobes_t r;
        r             = '0;
        r.detect_addr = (s == DECODE_ADDRESS);
        r.lfd_state   = (s == LOAD_FIRST_DATA);
        r.ld_state    = (s == LOAD_DATA);
        r.laf_state   = (s == LOAD_AFTER_FULL);
        r.full_state  = (s == FIFO_FULL_STATE);
        r.rst_int_reg = (s == CHECK_PARITY_ERROR);
        return r;
    endfunction

endpackage

// File: rtl/router_reg_if.sv
// Controller/source-facing bus of the router register stage.
interface router_reg_if;
    import router_pkg::*;

    logic  pkt_valid;
    byte_t data_in;
    logic  fifo_full;
    logic  detect_addr;
    logic  lfd_state;
    logic  ld_state;
    logic  laf_state;
    logic  full_state;
    logic  rst_int_reg;
    byte_t dout;
    logic  parity_done;
    logic  low_pkt_valid;
    logic  err;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  dout, parity_done, low_pkt_valid, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output dout, parity_done, low_pkt_valid, err
    );
endinterface

// File: rtl/router_parity_chk.sv
// Running XOR parity over header+payload, capture of the trailing parity byte, and error flag.
module router_parity_chk
    import router_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  detect_addr_i,
    input  logic  lfd_state_i,
    input  logic  ld_state_i,
    input  logic  laf_state_i,
    input  logic  full_state_i,
    input  logic  pkt_valid_i,
    input  byte_t data_i,
    input  byte_t header_i,
    input  logic  parity_done_i,
    input  logic  low_pkt_valid_i,
    output logic  err_o
);

    byte_t int_parity_q, int_parity_d;
    byte_t pkt_parity_q, pkt_parity_d;
    logic  err_q, err_d;
    logic  evaluated_q, evaluated_d;

    always_comb begin
        int_parity_d = int_parity_q;
        pkt_parity_d = pkt_parity_q;
        err_d        = err_q;
        evaluated_d  = evaluated_q;

        if (detect_addr_i) begin
            int_parity_d = '0;
        end else if (lfd_state_i) begin
            int_parity_d = int_parity_q ^ header_i;
        end else if (ld_state_i && pkt_valid_i && !full_state_i) begin
            int_parity_d = int_parity_q ^ data_i;
        end

        // Only the first parity-byte cycle of a packet is captured.
        if (detect_addr_i) begin
            pkt_parity_d = '0;
        end else if (!parity_done_i &&
                     ((ld_state_i && !pkt_valid_i) || (laf_state_i && low_pkt_valid_i))) begin
            pkt_parity_d = data_i;
        end

        // One compare per packet, the cycle after parity_done is seen high.
        if (detect_addr_i) begin
            err_d       = 1'b0;
            evaluated_d = 1'b0;
        end else if (parity_done_i && !evaluated_q) begin
            err_d       = (int_parity_q != pkt_parity_q);
            evaluated_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            int_parity_q <= '0;
            pkt_parity_q <= '0;
            err_q        <= 1'b0;
            evaluated_q  <= 1'b0;
        end else begin
            int_parity_q <= int_parity_d;
            pkt_parity_q <= pkt_parity_d;
            err_q        <= err_d;
            evaluated_q  <= evaluated_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, FIFO write byte, full-hold byte and parity status.
module router_reg
    import router_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    router_reg_if.slave  bus
);

    byte_t header_q, header_d;
    byte_t hold_q, hold_d;
    byte_t dout_q, dout_d;
    logic  parity_done_q, parity_done_d;
    logic  low_pkt_valid_q, low_pkt_valid_d;
    logic  err_w;

    always_comb begin
        header_d        = header_q;
        hold_d          = hold_q;
        dout_d          = dout_q;
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;

        if (bus.detect_addr && bus.pkt_valid && addr_valid(bus.data_in)) begin
            header_d = bus.data_in;
        end

        // A byte arriving while the FIFO is full is parked and replayed from LOAD_AFTER_FULL.
        if (bus.lfd_state) begin
            dout_d = header_q;
        end else if (bus.ld_state && !bus.fifo_full) begin
            dout_d = bus.data_in;
        end else if (bus.ld_state) begin
            hold_d = bus.data_in;
        end else if (bus.laf_state) begin
            dout_d = hold_q;
        end

        if (bus.detect_addr) begin
            parity_done_d = 1'b0;
        end else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                     (bus.laf_state && low_pkt_valid_q && !parity_done_q)) begin
            parity_done_d = 1'b1;
        end

        if (bus.rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end else if (bus.ld_state && !bus.pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            header_q        <= '0;
            hold_q          <= '0;
            dout_q          <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
        end else begin
            header_q        <= header_d;
            hold_q          <= hold_d;
            dout_q          <= dout_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
        end
    end

    router_parity_chk u_parity_chk (
        .clk             (clk),
        .rst             (rst),
        .detect_addr_i   (bus.detect_addr),
        .lfd_state_i     (bus.lfd_state),
        .ld_state_i      (bus.ld_state),
        .laf_state_i     (bus.laf_state),
        .full_state_i    (bus.full_state),
        .pkt_valid_i     (bus.pkt_valid),
        .data_i          (bus.data_in),
        .header_i        (header_q),
        .parity_done_i   (parity_done_q),
        .low_pkt_valid_i (low_pkt_valid_q),
        .err_o           (err_w)
    );

    assign bus.dout          = dout_q;
    assign bus.parity_done   = parity_done_q;
    assign bus.low_pkt_valid = low_pkt_valid_q;
    assign bus.err           = err_w;

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: per-cycle vectors with hand-derived expected outputs.
module tb_router_reg;
    import router_pkg::*;

    typedef struct {
        logic          rst_n;
        router_state_e st;
        logic          pv;
        logic          ff;
        byte_t         d;
        byte_t         e_dout;
        logic          e_pd;
        logic          e_lpv;
        logic          e_err;
    } vec_t;

    typedef struct {
        int    idx;
        byte_t dout;
        logic  pd;
        logic  lpv;
        logic  err;
    } exp_t;

    logic clk;
    logic rst;
    router_reg_if bus();

    router_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp;
    int   n_mis;
    int   vec_no;
    exp_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(logic r, router_state_e s, logic pv, logic ff, byte_t d,
                                byte_t ed, logic epd, logic elpv, logic eerr);
        vec_t v;
        v.rst_n = r;  v.st = s;  v.pv = pv;  v.ff = ff;  v.d = d;
        v.e_dout = ed;  v.e_pd = epd;  v.e_lpv = elpv;  v.e_err = eerr;
        return v;
    endfunction

    task automatic cmp(input int idx, input string what, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL v%0d %s: got %02h expected %02h", idx, what, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL scoreboard: empty at sample time");
            return;
        end
        e = sb.pop_front();
        cmp(e.idx, "dout",          bus.dout,                 e.dout);
        cmp(e.idx, "parity_done",   8'(bus.parity_done),      8'(e.pd));
        cmp(e.idx, "low_pkt_valid", 8'(bus.low_pkt_valid),    8'(e.lpv));
        cmp(e.idx, "err",           8'(bus.err),              8'(e.err));
    endtask

    task automatic apply(input vec_t v);
        strobes_t s;
        exp_t     e;
        @(negedge clk);
        s               = state_strobes(v.st);
        rst             = v.rst_n;
        bus.pkt_valid   = v.pv;
        bus.fifo_full   = v.ff;
        bus.data_in     = v.d;
        bus.detect_addr = s.detect_addr;
        bus.lfd_state   = s.lfd_state;
        bus.ld_state    = s.ld_state;
        bus.laf_state   = s.laf_state;
        bus.full_state  = s.full_state;
        bus.rst_int_reg = s.rst_int_reg;
        e.idx  = vec_no;
        e.dout = v.e_dout;
        e.pd   = v.e_pd;
        e.lpv  = v.e_lpv;
        e.err  = v.e_err;
        sb.push_back(e);
        vec_no++;
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        clk = 1'b0;  rst = 1'b0;  n_cmp = 0;  n_mis = 0;  vec_no = 0;
        bus.pkt_valid = 1'b0;  bus.fifo_full = 1'b0;  bus.data_in = '0;
        bus.detect_addr = 1'b0;  bus.lfd_state = 1'b0;  bus.ld_state = 1'b0;
        bus.laf_state = 1'b0;  bus.full_state = 1'b0;  bus.rst_int_reg = 1'b0;

        // Reset, good packet 05/11/22 parity 36, then same packet with bad parity 37.
        tbl.push_back(mk(0, DECODE_ADDRESS,     0, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, DECODE_ADDRESS,     0, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, DECODE_ADDRESS,     1, 0, 8'h05, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, LOAD_FIRST_DATA,    1, 0, 8'h11, 8'h05, 0, 0, 0));
        tbl.push_back(mk(1, LOAD_DATA,          1, 0, 8'h11, 8'h11, 0, 0, 0));
        tbl.push_back(mk(1, LOAD_DATA,          1, 0, 8'h22, 8'h22, 0, 0, 0));
        tbl.push_back(mk(1, LOAD_DATA,          0, 0, 8'h36, 8'h36, 1, 1, 0));
        tbl.push_back(mk(1, CHECK_PARITY_ERROR, 0, 0, 8'h36, 8'h36, 1, 0, 0));
        tbl.push_back(mk(1, DECODE_ADDRESS,     1, 0, 8'h05, 8'h36, 0, 0, 0));
        tbl.push_back(mk(1, LOAD_FIRST_DATA,    1, 0, 8'h11, 8'h05, 0, 0, 0));
        tbl.push_back(mk(1, LOAD_DATA,          1, 0, 8'h11, 8'h11, 0, 0, 0));
        tbl.push_back(mk(1, LOAD_DATA,          1, 0, 8'h22, 8'h22, 0, 0, 0));
        tbl.push_back(mk(1, LOAD_DATA,          0, 0, 8'h37, 8'h37, 1, 1, 0));
        tbl.push_back(mk(1, CHECK_PARITY_ERROR, 0, 0, 8'h37, 8'h37, 1, 0, 1));
        tbl.push_back(mk(1, WAIT_TILL_EMPTY,    0, 0, 8'h37, 8'h37, 1, 0, 1));
        tbl.push_back(mk(1, DECODE_ADDRESS,     1, 0, 8'h05, 8'h37, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // FIFO full on a payload byte: 44 parked, replayed from LOAD_AFTER_FULL, counted once in parity.
        apply(mk(1, LOAD_FIRST_DATA,    1, 0, 8'h11, 8'h05, 0, 0, 0));
        apply(mk(1, LOAD_DATA,          1, 0, 8'h11, 8'h11, 0, 0, 0));
        apply(mk(1, LOAD_DATA,          1, 1, 8'h44, 8'h11, 0, 0, 0));
        apply(mk(1, FIFO_FULL_STATE,    1, 1, 8'h44, 8'h11, 0, 0, 0));
        apply(mk(1, LOAD_AFTER_FULL,    1, 0, 8'h44, 8'h44, 0, 0, 0));
        apply(mk(1, LOAD_DATA,          0, 0, 8'h50, 8'h50, 1, 1, 0));
        apply(mk(1, CHECK_PARITY_ERROR, 0, 0, 8'h50, 8'h50, 1, 0, 0));

        // Parity byte arrives while full: parity_done only via the LOAD_AFTER_FULL path.
        apply(mk(1, DECODE_ADDRESS,     1, 0, 8'h05, 8'h50, 0, 0, 0));
        apply(mk(1, LOAD_FIRST_DATA,    1, 0, 8'h22, 8'h05, 0, 0, 0));
        apply(mk(1, LOAD_DATA,          1, 0, 8'h22, 8'h22, 0, 0, 0));
        apply(mk(1, LOAD_DATA,          0, 1, 8'h27, 8'h22, 0, 1, 0));
        apply(mk(1, FIFO_FULL_STATE,    0, 1, 8'h27, 8'h22, 0, 1, 0));
        apply(mk(1, LOAD_AFTER_FULL,    0, 0, 8'h27, 8'h27, 1, 1, 0));
        apply(mk(1, CHECK_PARITY_ERROR, 0, 0, 8'h27, 8'h27, 1, 0, 0));

        // Invalid header address keeps 05; then a bad packet is reset mid-flight.
        apply(mk(1, DECODE_ADDRESS,     1, 0, 8'h03, 8'h27, 0, 0, 0));
        apply(mk(1, LOAD_FIRST_DATA,    1, 0, 8'hA5, 8'h05, 0, 0, 0));
        apply(mk(1, LOAD_DATA,          1, 0, 8'hA5, 8'hA5, 0, 0, 0));
        apply(mk(1, LOAD_DATA,          0, 0, 8'hFF, 8'hFF, 1, 1, 0));
        apply(mk(1, WAIT_TILL_EMPTY,    0, 0, 8'hFF, 8'hFF, 1, 1, 1));
        apply(mk(0, LOAD_DATA,          1, 0, 8'h5A, 8'h00, 0, 0, 0));
        apply(mk(1, LOAD_FIRST_DATA,    1, 0, 8'h5A, 8'h00, 0, 0, 0));

        if (sb.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL scoreboard: %0d entries left unchecked", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 router, directly downstream of the router FSM controller. Consumes the controller's state strobes (detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Captures the header byte, passes payload bytes to the FIFO write bus, and holds a byte that arrives while the FIFO is full.
- Computes running XOR parity, compares it against the trailing parity byte, and returns parity_done / low_pkt_valid to the controller plus err to the top level.

Parameters:
DATA_WIDTH, 8, width of data_in/dout and of all parity registers
INVALID_ADDR, 2'b11, header address code that must not be latched

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-low reset
pkt_valid  input  1  source asserts while header/payload bytes are on data_in; deasserts with the parity byte
data_in  input  DATA_WIDTH  packet byte stream; header bits [1:0] = destination
fifo_full  input  1  selected destination FIFO full (from synchronizer)
detect_addr  input  1  controller in DECODE_ADDRESS
lfd_state  input  1  controller in LOAD_FIRST_DATA
ld_state  input  1  controller in LOAD_DATA
laf_state  input  1  controller in LOAD_AFTER_FULL
full_state  input  1  controller in FIFO_FULL_STATE
rst_int_reg  input  1  controller in CHECK_PARITY_ERROR
dout  output  DATA_WIDTH  byte to FIFO write port
parity_done  output  1  parity byte has been captured for current packet
low_pkt_valid  output  1  pkt_valid fell while loading (parity byte seen)
err  output  1  computed parity != received parity

Behaviour:
- Reset (rst==0 at clk edge): dout, header_byte, hold_byte, int_parity, pkt_parity = 0; parity_done, low_pkt_valid, err = 0. Reset overrides every other condition, including mid-packet.
- Header latch: detect_addr && pkt_valid && data_in[1:0]!=INVALID_ADDR -> header_byte <= data_in. Otherwise header_byte holds.
- dout updates (priority order, first match wins):
  - lfd_state -> dout <= header_byte
  - ld_state && !fifo_full -> dout <= data_in
  - ld_state && fifo_full -> hold_byte <= data_in; dout holds
  - laf_state -> dout <= hold_byte
  - else dout holds
- Latency: one cycle from data_in (or header_byte) to dout.
- Internal parity:
  - detect_addr -> int_parity <= 0
  - lfd_state -> int_parity <= int_parity ^ header_byte
  - ld_state && pkt_valid && !full_state -> int_parity <= int_parity ^ data_in
  - else holds. The parity byte itself is never XORed in.
- Packet parity:
  - detect_addr -> pkt_parity <= 0
  - ld_state && !pkt_valid (or laf_state && low_pkt_valid && !parity_done) -> pkt_parity <= data_in (first such cycle only; guarded by !parity_done)
- parity_done:
  - detect_addr -> 0
  - set to 1 on (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_pkt_valid && !parity_done)
  - sticky until the next detect_addr
- low_pkt_valid:
  - rst_int_reg -> 0
  - ld_state && !pkt_valid -> 1
  - else holds. Clear has priority over set.
- err:
  - detect_addr -> 0
  - registered compare: when parity_done==1 and err not yet evaluated for the packet, err <= (int_parity != pkt_parity), evaluated the cycle after parity_done rises
  - held until the next detect_addr
- Boundary cases:
  - fifo_full in the same cycle the parity byte arrives: byte goes to hold_byte; parity_done is set later via the laf path.
  - Back-to-back packets: detect_addr clears parity state in the same cycle the new header latches.
  - Invalid header address: no latch.
  - Strobes are one-hot from the controller. Simultaneous strobes resolve by the priority order above.

Decomposition:
- Shared package router_pkg: DATA_WIDTH, INVALID_ADDR, and the 3-bit FSM state encodings used by the controller, so the bench can decode state.
- One natural sub-module: router_parity_chk. It holds int_parity, pkt_parity and err, and takes header_byte, data_in and the strobes.
- dout/hold/header logic stays in router_reg.

Test Plan:
- Reset mid-packet: rst=0 while ld_state with dout=8'hA5 -> next edge: dout=0, parity_done=0, low_pkt_valid=0, err=0.
- Good packet: header 8'h05 (addr 1), payload 8'h11, 8'h22, parity 8'h36 -> dout sequence 05, 11, 22, 36, one cycle late; parity_done=1 after parity byte; err=0.
- Bad parity: same packet with parity byte 8'h37 -> parity_done=1, err=1 the following cycle; err cleared on next detect_addr.
- FIFO full: fifo_full=1 during ld_state with data_in=8'h44 -> dout holds previous value, hold_byte=8'h44; laf_state next -> dout=8'h44; int_parity unchanged while full_state.
- Parity byte during full: pkt_valid=0 with fifo_full=1 -> low_pkt_valid=1, parity_done=0; laf_state -> parity_done=1; rst_int_reg -> low_pkt_valid=0.
- Invalid address: detect_addr, pkt_valid, data_in=8'h03 -> header_byte unchanged (previous 8'h05); lfd_state outputs 8'h05.
